double_mat_loader: RTL and testbench
====================================

Name: double_mat_loader

Overview:
- Upstream feeder for the parallel double-precision matrix multiplier.
- Accepts a serial valid/ready stream of 64-bit IEEE-754 doubles in row-major order, first matrix A (SIZE_A x SIZE_B), then matrix B (SIZE_B x SIZE_C).
- Presents A and B as stable parallel arrays, holds the multiplier's start/clock-enable high until it reports done, then re-arms it with a one-cycle reset pulse.
- Lets ICA/whitening stages stream operands from memory without building full matrices themselves.

Parameters:
- SIZE_A, 8, rows of A
- SIZE_B, 8, columns of A / rows of B
- SIZE_C, 8, columns of B
- TIMEOUT, 1024, maximum cycles to wait in RUN for mul_done
- FCNT_W, 16, width of frame counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (0 at a posedge resets)
- in_data  in  64 (double)  stream element
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_last  in  1  marks final element of B
- mat_a  out  double[SIZE_A][SIZE_B]  operand A to multiplier
- mat_b  out  double[SIZE_B][SIZE_C]  operand B to multiplier
- mul_start  out  1  multiplier start/clock enable
- mul_rst  out  1  multiplier reset, active-high
- mul_done  in  1  multiplier finished flag (level, held until reset)
- result_valid  out  1  one-cycle pulse: product on multiplier output is valid
- frame_err  out  1  sticky, in_last misplaced
- timeout  out  1  sticky, mul_done not seen within TIMEOUT
- frame_count  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Reset values: state LOAD_A, row/col/watchdog counters 0, mat_a/mat_b all 0, mul_start 0, mul_rst 1, result_valid 0, frame_err 0, timeout 0, frame_count 0. Reset mid-operation aborts the frame; partially loaded data is zeroed.
- mul_rst is 1 during reset, drops to 0 on the first cycle after reset release, and is otherwise 1 only in RECOVER.
- Handshake: beat = in_valid & in_ready. in_ready = 1 exactly in LOAD_A and LOAD_B (combinational from state). in_data is ignored otherwise.
- LOAD_A: each beat writes mat_a[r][c], c increments, wraps at SIZE_B-1 with r++. After SIZE_A*SIZE_B beats: r, c cleared, go to LOAD_B.
- LOAD_B: same scheme into mat_b[r][c], c wrapping at SIZE_C-1. The beat on the final element enters RUN. mul_start = 1 registered, so it rises the cycle after the final beat.
- in_last is checked only, never used for sequencing. in_last=1 on any beat other than the final B element, or in_last=0 on the final element, sets frame_err. The block keeps counting regardless.
- RUN: mul_start = 1; mat_a/mat_b frozen; watchdog increments each cycle.
  - mul_done = 1 → DONE.
  - Else watchdog == TIMEOUT-1 → set timeout, go RECOVER (no result_valid, no frame_count increment).
  - mul_done is ignored outside RUN.
- DONE (one cycle): result_valid = 1, mul_start = 0, frame_count++ (wraps), then RECOVER.
- RECOVER (one cycle): mul_rst = 1, mul_start = 0, watchdog cleared, then LOAD_A.
- Next frame's first beat can be accepted 2 cycles after mul_done is sampled high (DONE, RECOVER, then LOAD_A).
- mat_a/mat_b retain values until overwritten, so the product read at result_valid remains consistent.
- Backpressure-free source (in_valid held 1): full frame load takes SIZE_A*SIZE_B + SIZE_B*SIZE_C cycles.

Decomposition:
- Package fp_double: existing double typedef (64-bit).
- Package fsm_matop: add state_mload enum {LOAD_A_ML, LOAD_B_ML, RUN_ML, DONE_ML, RECOVER_ML}.
- One sub-module, mat_idx_counter (parameters ROWS, COLS; inputs clk, rst, clr, inc; outputs row, col, wrap). Instantiate it twice, once per matrix.
- Watchdog and frame counter stay inline.

Test Plan:
- SIZE 2x2x2; stream A = {1.0, 2.0, 3.0, 4.0}, B = {5.0, 6.0, 7.0, 8.0}, in_valid held 1, in_last on beat 8, mul_done model asserts 10 cycles after mul_start → mat_a[1][0] = 3.0, mat_b[0][1] = 6.0, mul_start rises the cycle after beat 8, result_valid pulses once, frame_count = 1, frame_err = 0.
- Same frame with in_valid toggling 1/0 every cycle → identical matrices; in_ready = 0 throughout RUN/DONE/RECOVER; the loader consumes no beats while in_ready = 0.
- in_last asserted on beat 3 and deasserted on beat 8 → frame_err = 1 and stays 1; frame still completes and frame_count increments.
- TIMEOUT = 16, mul_done never asserted → timeout = 1 on cycle 16 of RUN, mul_rst pulses for one cycle, no result_valid, frame_count unchanged, loader back in LOAD_A.
- rst = 0 asserted after 5 of 8 beats → next cycle: all outputs at reset values, mul_rst = 1; after release a complete new frame loads correctly from element A[0][0].
- Run 3 back-to-back frames → next frame's first beat accepted exactly 2 cycles after mul_done sampled, frame_count = 3.

Source files
------------

// File: rtl/double_mat_loader_pkg.sv
// Shared types for the double-precision matrix loader: operand word, FSM states,
// and the index-width helper used by the row/column counters.
package double_mat_loader_pkg;

  typedef logic [63:0] double_t;

  typedef enum logic [2:0] {
    LOAD_A_ML  = 3'd0,
    LOAD_B_ML  = 3'd1,
    RUN_ML     = 3'd2,
    DONE_ML    = 3'd3,
    RECOVER_ML = 3'd4
  } state_mload;

  // Index width for a dimension of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Row-major (row, col) walker over a ROWS x COLS matrix; wrap flags the
// increment that consumes the last element and returns the walk to (0,0).
module mat_idx_counter
  import double_mat_loader_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = idx_w(ROWS),
  localparam int CW = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          wrap
);

  logic [RW-1:0] row_r;
  logic [CW-1:0] col_r;
  logic          row_last_s;
  logic          col_last_s;

  assign row_last_s = (row_r == RW'(ROWS - 1));
  assign col_last_s = (col_r == CW'(COLS - 1));
  assign wrap       = inc & row_last_s & col_last_s;
  assign row        = row_r;
  assign col        = col_r;

  // Advance column first, carrying into the row at the end of each row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_r <= RW'(0);
      col_r <= CW'(0);
    end else if (clr) begin
      row_r <= RW'(0);
      col_r <= CW'(0);
    end else if (inc) begin
      if (col_last_s) begin
        col_r <= CW'(0);
        row_r <= row_last_s ? RW'(0) : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/double_mat_loader.sv
// Serial-to-parallel operand loader for the double matrix multiplier: fills A then B
// from a valid/ready stream, runs the multiplier under a watchdog, then re-arms it.
module double_mat_loader
  import double_mat_loader_pkg::*;
#(
  parameter int SIZE_A  = 8,
  parameter int SIZE_B  = 8,
  parameter int SIZE_C  = 8,
  parameter int TIMEOUT = 1024,
  parameter int FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  double_t           in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output double_t           mat_a [SIZE_A][SIZE_B],
  output double_t           mat_b [SIZE_B][SIZE_C],
  output logic              mul_start,
  output logic              mul_rst,
  input  logic              mul_done,
  output logic              result_valid,
  output logic              frame_err,
  output logic              timeout,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int AR_W = idx_w(SIZE_A);
  localparam int AC_W = idx_w(SIZE_B);
  localparam int BR_W = idx_w(SIZE_B);
  localparam int BC_W = idx_w(SIZE_C);
  localparam int WD_W = idx_w(TIMEOUT);

  state_mload        state_r, state_next_s;
  logic [WD_W-1:0]   wd_r;
  logic              mul_start_r, mul_rst_r, result_valid_r, frame_err_r, timeout_r;
  logic [FCNT_W-1:0] frame_count_r;
  double_t           mat_a_r [SIZE_A][SIZE_B];
  double_t           mat_b_r [SIZE_B][SIZE_C];

  logic              beat_s, a_inc_s, b_inc_s, idx_clr_s, wd_expired_s;
  logic              a_wrap_s, b_wrap_s;
  logic [AR_W-1:0]   a_row_s;
  logic [AC_W-1:0]   a_col_s;
  logic [BR_W-1:0]   b_row_s;
  logic [BC_W-1:0]   b_col_s;

  assign in_ready     = (state_r == LOAD_A_ML) || (state_r == LOAD_B_ML);
  assign beat_s       = in_valid & in_ready;
  assign a_inc_s      = beat_s & (state_r == LOAD_A_ML);
  assign b_inc_s      = beat_s & (state_r == LOAD_B_ML);
  assign idx_clr_s    = (state_r == RECOVER_ML);
  assign wd_expired_s = (wd_r == WD_W'(TIMEOUT - 1));

  mat_idx_counter #(.ROWS(SIZE_A), .COLS(SIZE_B)) u_idx_a (
    .clk(clk), .rst(rst), .clr(idx_clr_s), .inc(a_inc_s),
    .row(a_row_s), .col(a_col_s), .wrap(a_wrap_s)
  );

  mat_idx_counter #(.ROWS(SIZE_B), .COLS(SIZE_C)) u_idx_b (
    .clk(clk), .rst(rst), .clr(idx_clr_s), .inc(b_inc_s),
    .row(b_row_s), .col(b_col_s), .wrap(b_wrap_s)
  );

  // Frame sequencing; mul_done only matters while the multiplier is running.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LOAD_A_ML: begin
        if (a_wrap_s) state_next_s = LOAD_B_ML;
        else          state_next_s = LOAD_A_ML;
      end
      LOAD_B_ML: begin
        if (b_wrap_s) state_next_s = RUN_ML;
        else          state_next_s = LOAD_B_ML;
      end
      RUN_ML: begin
        if (mul_done)          state_next_s = DONE_ML;
        else if (wd_expired_s) state_next_s = RECOVER_ML;
        else                   state_next_s = RUN_ML;
      end
      DONE_ML:    state_next_s = RECOVER_ML;
      RECOVER_ML: state_next_s = LOAD_A_ML;
      default:    state_next_s = LOAD_A_ML;
    endcase
  end

  // State, watchdog, status flags; strobes are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= LOAD_A_ML;
      wd_r           <= WD_W'(0);
      mul_start_r    <= 1'b0;
      mul_rst_r      <= 1'b1;
      result_valid_r <= 1'b0;
      frame_err_r    <= 1'b0;
      timeout_r      <= 1'b0;
      frame_count_r  <= FCNT_W'(0);
    end else begin
      state_r        <= state_next_s;
      mul_start_r    <= (state_next_s == RUN_ML);
      mul_rst_r      <= (state_next_s == RECOVER_ML);
      result_valid_r <= (state_next_s == DONE_ML);
      if (state_r == RUN_ML)          wd_r <= wd_r + WD_W'(1);
      else if (state_r == RECOVER_ML) wd_r <= WD_W'(0);
      // in_last is a framing check only: it must coincide with the final B element.
      if (beat_s && (in_last != b_wrap_s)) frame_err_r <= 1'b1;
      if ((state_r == RUN_ML) && !mul_done && wd_expired_s) timeout_r <= 1'b1;
      if (state_next_s == DONE_ML) frame_count_r <= frame_count_r + FCNT_W'(1);
    end
  end

  // Operand storage; held between frames so the product stays consistent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < SIZE_A; r++)
        for (int c = 0; c < SIZE_B; c++) mat_a_r[r][c] <= 64'd0;
      for (int r = 0; r < SIZE_B; r++)
        for (int c = 0; c < SIZE_C; c++) mat_b_r[r][c] <= 64'd0;
    end else begin
      if (a_inc_s) mat_a_r[a_row_s][a_col_s] <= in_data;
      if (b_inc_s) mat_b_r[b_row_s][b_col_s] <= in_data;
    end
  end

  assign mat_a        = mat_a_r;
  assign mat_b        = mat_b_r;
  assign mul_start    = mul_start_r;
  assign mul_rst      = mul_rst_r;
  assign result_valid = result_valid_r;
  assign frame_err    = frame_err_r;
  assign timeout      = timeout_r;
  assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_double_mat_loader.sv
// Scoreboard bench for double_mat_loader (2x2x2, TIMEOUT 16): a driver streams frames and
// queues expected results, a monitor checks every frame end and handshake timing.
module tb_double_mat_loader;

  localparam int SA = 2, SB = 2, SC = 2, TO = 16, FW = 16;
  localparam int DONE_LAT = 10;

  typedef struct packed {
    logic [3:0][63:0] a;
    logic [3:0][63:0] b;
    logic [15:0]      fc;
    logic             ferr;
    logic             tout;
    logic             done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   in_data = 64'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [63:0]   mat_a [SA][SB];
  logic [63:0]   mat_b [SB][SC];
  logic          mul_start, mul_rst, result_valid, frame_err, timeout;
  logic          mul_done = 1'b0;
  logic [FW-1:0] frame_count;

  int   n_cmp = 0, n_err = 0;
  exp_t sbq[$];
  bit   doneq[$];
  int   fc_m = 0;
  bit   ferr_m = 1'b0, tout_m = 1'b0;

  double_mat_loader #(.SIZE_A(SA), .SIZE_B(SB), .SIZE_C(SC), .TIMEOUT(TO), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .mat_a(mat_a), .mat_b(mat_b), .mul_start(mul_start), .mul_rst(mul_rst),
    .mul_done(mul_done), .result_valid(result_valid), .frame_err(frame_err),
    .timeout(timeout), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_reset_state();
    for (int r = 0; r < SA; r++)
      for (int c = 0; c < SB; c++) chk("reset mat_a", mat_a[r][c], 64'd0);
    for (int r = 0; r < SB; r++)
      for (int c = 0; c < SC; c++) chk("reset mat_b", mat_b[r][c], 64'd0);
    chk("reset mul_start", 64'(mul_start), 64'd0);
    chk("reset mul_rst", 64'(mul_rst), 64'd1);
    chk("reset result_valid", 64'(result_valid), 64'd0);
    chk("reset frame_err", 64'(frame_err), 64'd0);
    chk("reset timeout", 64'(timeout), 64'd0);
    chk("reset frame_count", 64'(frame_count), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
  endtask

  // Multiplier stand-in: raises done DONE_LAT cycles into a run (if enabled), clears on mul_rst.
  int cnt_d = 0;
  bit cur_en_d = 1'b0, ms_prev_d = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mul_rst) begin
        mul_done = 1'b0;
        cnt_d = 0;
      end else if (mul_start) begin
        if (!ms_prev_d) begin
          if (doneq.size() > 0) cur_en_d = doneq.pop_front();
          else cur_en_d = 1'b0;
          cnt_d = 0;
        end
        cnt_d++;
        if (cur_en_d && cnt_d >= DONE_LAT) mul_done = 1'b1;
      end
      ms_prev_d = mul_start;
    end
  end

  // Driver: queues the expected frame result, then streams the beats.
  task automatic send_frame(input logic [3:0][63:0] a, input logic [3:0][63:0] b, input int mode,
                            input logic [7:0] last_mask, input bit done_en, input int nbeats);
    exp_t e;
    if (nbeats == 8) begin
      for (int i = 0; i < 8; i++) if (last_mask[i] != (i == 7)) ferr_m = 1'b1;
      if (done_en) fc_m++;
      else tout_m = 1'b1;
      e.a = a; e.b = b; e.fc = 16'(fc_m); e.ferr = ferr_m; e.tout = tout_m; e.done = done_en;
      sbq.push_back(e);
      doneq.push_back(done_en);
    end
    for (int i = 0; i < nbeats; i++) begin
      int gaps;
      int n;
      gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
        in_last = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data = (i < 4) ? a[i] : b[i-4];
      in_last = last_mask[i];
      n = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        n++;
        if (n > 200) begin
          n_cmp++; n_err++;
          $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles, required 1", n);
          break;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d frames still pending, required 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor state
  int beats = 0, ms_cnt = 0, rv_cnt = 0, ncount = 0, last_beat_n = 0, done_n = 0;
  bit ms_prev = 1'b0, prev_rst = 1'b0, armed = 1'b0;

  task automatic frame_end();
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL frame_expected: frame ended with 0 pending, required >=1");
    end else begin
      e = sbq.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk("mat_a", mat_a[i/SB][i%SB], e.a[i]);
        chk("mat_b", mat_b[i/SC][i%SC], e.b[i]);
      end
      chk("frame_count", 64'(frame_count), 64'(e.fc));
      chk("frame_err", 64'(frame_err), 64'(e.ferr));
      chk("timeout", 64'(timeout), 64'(e.tout));
      chk("result_valid_pulses", 64'(rv_cnt), 64'(e.done));
      chk("mul_start_cycles", 64'(ms_cnt), e.done ? 64'(DONE_LAT) : 64'(TO));
    end
    beats = 0; ms_cnt = 0; rv_cnt = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ncount++;
      if (!rst) begin
        beats = 0; ms_cnt = 0; rv_cnt = 0; armed = 1'b0; ms_prev = 1'b0; prev_rst = 1'b0;
      end else begin
        if (mul_start && !ms_prev) begin
          chk("start_beats", 64'(beats), 64'd8);
          chk("start_latency", 64'(ncount - last_beat_n), 64'd1);
        end
        if (mul_start || result_valid || (mul_rst && prev_rst))
          chk("ready_low_busy", 64'(in_ready), 64'd0);
        // DONE, RECOVER, then LOAD_A: in_ready returns on the third falling edge.
        if (armed && in_ready) begin
          chk("rearm_latency", 64'(ncount - done_n), 64'd3);
          armed = 1'b0;
        end
        if (mul_done && mul_start) begin
          armed = 1'b1;
          done_n = ncount;
        end
        if (in_valid && in_ready) begin
          beats++;
          last_beat_n = ncount;
        end
        if (mul_start) ms_cnt++;
        if (result_valid) rv_cnt++;
        if (mul_rst && prev_rst) frame_end();
        ms_prev = mul_start;
        prev_rst = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_time: simulation exceeded 400000 time units");
    $fatal(1);
  end

  // Stimulus
  initial begin
    logic [3:0][63:0] ta, tb, ra, rb;
    logic [7:0] mask;
    bit den;
    for (int i = 0; i < 4; i++) begin
      ta[i] = $realtobits(real'(i + 1));
      tb[i] = $realtobits(real'(i + 5));
    end

    @(posedge clk); @(negedge clk);
    check_reset_state();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mul_rst_after_release", 64'(mul_rst), 64'd0);
    @(posedge clk); #1;

    send_frame(ta, tb, 0, 8'h80, 1'b1, 8); drain();
    send_frame(ta, tb, 1, 8'h80, 1'b1, 8); drain();
    send_frame(ta, tb, 0, 8'h04, 1'b1, 8); drain();
    for (int i = 0; i < 4; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom};
    end
    send_frame(ra, rb, 2, 8'h80, 1'b0, 8); drain();
    @(negedge clk);
    chk("back_in_load_a", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Abort a frame after five beats.
    send_frame(ra, rb, 0, 8'h80, 1'b1, 5);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_state();
    @(posedge clk); #1 rst = 1'b1;
    sbq.delete(); doneq.delete();
    fc_m = 0; ferr_m = 1'b0; tout_m = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mul_rst_after_abort", 64'(mul_rst), 64'd0);
    @(posedge clk); #1;

    // Three frames back to back.
    send_frame(ta, tb, 0, 8'h80, 1'b1, 8);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = {$urandom, $urandom};
        rb[i] = {$urandom, $urandom};
      end
      send_frame(ra, rb, 0, 8'h80, 1'b1, 8);
    end
    drain();
    chk("frame_count_b2b", 64'(frame_count), 64'd3);

    // Random gaps, occasional misplaced in_last or missing mul_done.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = {$urandom, $urandom};
        rb[i] = {$urandom, $urandom};
      end
      mask = 8'h80;
      if ($urandom_range(0, 3) == 0) mask = mask ^ (8'h01 << $urandom_range(0, 7));
      den = ($urandom_range(0, 3) != 0);
      send_frame(ra, rb, 2, mask, den, 8);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
